// File: rtl/dec_pkg.sv
// Shared definitions for the decoder-select round-robin arbiter.
package dec_pkg;

  localparam int NUM_REQ = 3;
  localparam int SEL_W   = 3;
  localparam int PTR_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search order is ptr+1, ptr+2, ptr (mod 3); ptr is the last grantee.
module rr_pick3
  import dec_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_any
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    // NOTE: every output gets a default before any conditional update,
    // otherwise the tool infers a latch to hold the old value.
    win_oh  = '0;
    win_idx = '0;
    win_any = |req;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_sel_arbiter.sv
// Round-robin owner of the 3-to-8 decoder select lines: bounded dwell per
// grant and a one-cycle dead gap between consecutive owners.
module dec_sel_arbiter
  import dec_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   code0,
  input  logic [SEL_W-1:0]   code1,
  input  logic [SEL_W-1:0]   code2,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_vld,
  output logic               busy
);

  if (HOLD_CYC < 1 || longint'(HOLD_CYC) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_hold
    $error("dec_sel_arbiter: HOLD_CYC out of range for CNT_W");
  end

  state_e             r_state,   w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [PTR_W-1:0]   r_ptr,     w_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
  logic [SEL_W-1:0]   r_sel,     w_sel_nxt;
  logic               r_sel_vld, w_sel_vld_nxt;
  logic               r_busy,    w_busy_nxt;

  logic [NUM_REQ-1:0] w_win_oh;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_win_any;
  logic [SEL_W-1:0]   w_win_code;

  rr_pick3 u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx),
    .win_any (w_win_any)
  );

  always_comb begin
    case (w_win_idx)
      2'd0:    w_win_code = code0;
      2'd1:    w_win_code = code1;
      default: w_win_code = code2;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_sel_vld_nxt = r_sel_vld;

    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_win_any) begin
          w_state_nxt   = ST_GRANT;
          w_grant_nxt   = w_win_oh;
          w_sel_nxt     = w_win_code;
          w_sel_vld_nxt = 1'b1;
          w_cnt_nxt     = CNT_W'(HOLD_CYC - 1);
          w_ptr_nxt     = w_win_idx;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_sel_nxt     = '0;
          w_sel_vld_nxt = 1'b0;
        end
      end

      ST_GRANT: begin
        // sel stays frozen; only dwell expiry or the grantee dropping req ends it.
        if (r_cnt == '0 || (req & r_grant) == '0) begin
          w_state_nxt   = ST_GAP;
          w_grant_nxt   = '0;
          w_sel_nxt     = '0;
          w_sel_vld_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_grant_nxt   = '0;
        w_sel_nxt     = '0;
        w_sel_vld_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ptr     <= 2'd2;
      r_grant   <= '0;
      r_sel     <= '0;
      r_sel_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_sel_vld <= w_sel_vld_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign sel_vld = r_sel_vld;
  assign busy    = r_busy;

endmodule

// File: tb/tb_dec_sel_arbiter.sv
// Self-checking bench: a HOLD_CYC=4 and a HOLD_CYC=1 arbiter run side by side
// against a grant/dwell/gap reference model, with directed and random stimulus.
module tb_dec_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_a, a_c0, a_c1, a_c2;
  logic [2:0] req_b, b_c0, b_c1, b_c2;
  logic [2:0] a_grant, a_sel, b_grant, b_sel;
  logic       a_vld, a_busy, b_vld, b_busy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model, one slot per DUT: current owner (-1 none), grant cycles
  // still to serve, gap flag, last grantee and the code captured at grant.
  int         m_owner [2];
  int         m_left  [2];
  bit         m_gap   [2];
  int         m_last  [2];
  logic [2:0] m_sel   [2];
  int         m_hold  [2] = '{4, 1};

  always #5 clk = ~clk;

  dec_sel_arbiter #(.HOLD_CYC(4), .CNT_W(8)) u_dut (
    .sys_clk (clk), .sys_rst_n (rst_n), .req (req_a),
    .code0 (a_c0), .code1 (a_c1), .code2 (a_c2),
    .grant (a_grant), .sel (a_sel), .sel_vld (a_vld), .busy (a_busy)
  );

  dec_sel_arbiter #(.HOLD_CYC(1), .CNT_W(4)) u_dut1 (
    .sys_clk (clk), .sys_rst_n (rst_n), .req (req_b),
    .code0 (b_c0), .code1 (b_c1), .code2 (b_c2),
    .grant (b_grant), .sel (b_sel), .sel_vld (b_vld), .busy (b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_left[d]  = 0;
      m_gap[d]   = 1'b0;
      m_last[d]  = 2;
      m_sel[d]   = '0;
    end
  endtask

  task automatic model_step(input int d, input logic [2:0] r,
                            input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
    logic [2:0] codes [3];
    bit found;
    int cand;
    codes = '{c0, c1, c2};
    if (m_owner[d] >= 0) begin
      if (!r[m_owner[d]] || m_left[d] == 1) begin
        m_owner[d] = -1;
        m_gap[d]   = 1'b1;
      end else begin
        m_left[d]--;
      end
    end else begin
      m_gap[d] = 1'b0;
      found    = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        cand = (m_last[d] + k) % 3;
        if (!found && r[cand]) begin
          found      = 1'b1;
          m_owner[d] = cand;
          m_left[d]  = m_hold[d];
          m_last[d]  = cand;
          m_sel[d]   = codes[cand];
        end
      end
    end
  endtask

  task automatic cmp(input int d);
    logic [2:0] e_grant, e_sel;
    logic       e_vld, e_busy;
    e_grant = (m_owner[d] >= 0) ? 3'(1 << m_owner[d]) : 3'b000;
    e_sel   = (m_owner[d] >= 0) ? m_sel[d] : 3'd0;
    e_vld   = (m_owner[d] >= 0);
    e_busy  = (m_owner[d] >= 0) || m_gap[d];
    if (d == 0) begin
      check("h4_grant", 32'(a_grant), 32'(e_grant));
      check("h4_sel",   32'(a_sel),   32'(e_sel));
      check("h4_vld",   32'(a_vld),   32'(e_vld));
      check("h4_busy",  32'(a_busy),  32'(e_busy));
    end else begin
      check("h1_grant", 32'(b_grant), 32'(e_grant));
      check("h1_sel",   32'(b_sel),   32'(e_sel));
      check("h1_vld",   32'(b_vld),   32'(e_vld));
      check("h1_busy",  32'(b_busy),  32'(e_busy));
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, DUTs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_step(0, req_a, a_c0, a_c1, a_c2);
    model_step(1, req_b, b_c0, b_c1, b_c2);
    #1;
    cmp(0);
    cmp(1);
  endtask

  // Assert reset between edges, confirm outputs clear without a clock, release mid-cycle.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_grant", 32'(a_grant), 32'd0);
    check("rst_async_sel",   32'(a_sel),   32'd0);
    check("rst_async_vld",   32'(a_vld),   32'd0);
    cmp(0);
    cmp(1);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; a_c0 = '0; a_c1 = '0; a_c2 = '0;
    req_b = '0; b_c0 = 3'd4; b_c1 = 3'd1; b_c2 = 3'd6;
    model_reset();
    #12;
    cmp(0);
    cmp(1);
    check("reset_busy", 32'(a_busy), 32'd0);

    // Reset and first grant, then full rotation.
    req_a = 3'b111; a_c0 = 3'd5; a_c1 = 3'd2; a_c2 = 3'd3;
    req_b = 3'b101;
    rst_n = 1'b1;
    step();
    check("first_grant", 32'(a_grant), 32'h1);
    check("first_sel",   32'(a_sel),   32'd5);
    a_c0 = 3'd1;
    for (int i = 0; i < 3; i++) step();
    check("dwell_end_vld", 32'(a_vld), 32'd1);
    step();
    check("gap_vld", 32'(a_vld), 32'd0);
    check("gap_busy", 32'(a_busy), 32'd1);
    step();
    check("second_grant", 32'(a_grant), 32'h2);
    for (int i = 0; i < 12; i++) step();
    check("rotation_grant", 32'(a_grant), 32'h1);
    check("rotation_sel",   32'(a_sel),   32'd1);

    // Early release by requester 1.
    req_a = 3'b000;
    for (int i = 0; i < 6; i++) step();
    req_a = 3'b010;
    step();
    check("early_grant", 32'(a_grant), 32'h2);
    step();
    req_a = 3'b000;
    step();
    check("early_vld", 32'(a_vld), 32'd0);
    check("early_gap_busy", 32'(a_busy), 32'd1);
    step();
    check("early_idle_busy", 32'(a_busy), 32'd0);

    // Code freeze while requester 2 holds the grant.
    req_a = 3'b100; a_c2 = 3'd7;
    step();
    a_c2 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("freeze_sel", 32'(a_sel), 32'd7);
    end
    for (int i = 0; i < 3; i++) step();

    // Reset mid-grant, then ptr=2 makes requester 1 win over 2.
    req_a = 3'b000;
    for (int i = 0; i < 3; i++) step();
    req_a = 3'b111;
    step();
    step();
    pulse_reset();
    req_a = 3'b110;
    step();
    check("post_rst_grant", 32'(a_grant), 32'h2);

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req_a = 3'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 3'($urandom);
      a_c0 = 3'($urandom); a_c1 = 3'($urandom); a_c2 = 3'($urandom);
      b_c0 = 3'($urandom); b_c1 = 3'($urandom); b_c2 = 3'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
